// File: rtl/msrv32_trap_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_trap_ctrl
// Machine-mode trap and interrupt controller. Detects synchronous exceptions,
// enabled pending interrupts and MRET while OPERATING, then sequences trap
// entry (TRAP_TAKEN) or trap return (TRAP_RETURN) for exactly one cycle each.
//
// Build option: define MSRV32_MISALIGNED_TRAP_EN to let the misaligned
// instruction/load/store flags raise exceptions (causes 0/4/6). Without it
// those flags are ignored and misaligned_exception_out stays 0.
//
// Ports:
//   clk_in, rst_in                 clock, asynchronous active-high reset
//   opcode_6_to_2_in, funct3_in,
//   funct7_in, rs1/rs2/rd_addr_in  instruction fields for ECALL/EBREAK/MRET
//   illegal_instr_in               decoder illegal-instruction flag
//   misaligned_*_in                address-misaligned flags
//   mie/meie/mtie/msie/meip/mtip/msip_in  CSR enable/pending bits
//   i_or_e_out                     1 = interrupt, 0 = exception (registered)
//   set_cause_out, cause_out       mcause write strobe and code (registered)
//   set_epc_out                    capture PC into mepc
//   instret_inc_out                retire current instruction
//   mie_clear_out, mie_set_out     clear/set mstatus.MIE
//   misaligned_exception_out       registered trap was misaligned
//   pc_src_out                     00 boot, 01 mepc, 10 trap vector, 11 next
//   flush_out                      kill the instruction in the pipeline
// ---------------------------------------------------------------------------
module msrv32_trap_ctrl (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [4:0] opcode_6_to_2_in,
   input  logic [2:0] funct3_in,
   input  logic [6:0] funct7_in,
   input  logic [4:0] rs1_addr_in,
   input  logic [4:0] rs2_addr_in,
   input  logic [4:0] rd_addr_in,
   input  logic       illegal_instr_in,
   input  logic       misaligned_instr_in,
   input  logic       misaligned_load_in,
   input  logic       misaligned_store_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       meip_in,
   input  logic       mtip_in,
   input  logic       msip_in,
   output logic       i_or_e_out,
   output logic       set_cause_out,
   output logic [3:0] cause_out,
   output logic       set_epc_out,
   output logic       instret_inc_out,
   output logic       mie_clear_out,
   output logic       mie_set_out,
   output logic       misaligned_exception_out,
   output logic [1:0] pc_src_out,
   output logic       flush_out
);

   typedef enum logic [1:0] {
      RESET       = 2'b00,
      OPERATING   = 2'b01,
      TRAP_TAKEN  = 2'b10,
      TRAP_RETURN = 2'b11
   } state_t;

   state_t     state, next_state;

   logic       is_system, is_ecall, is_ebreak, is_mret;
   logic       mis_instr, mis_load, mis_store;
   logic       exc, irq, trap;
   logic       exc_mis;
   logic [3:0] exc_cause, irq_cause;

`ifdef MSRV32_MISALIGNED_TRAP_EN
   assign mis_instr = misaligned_instr_in;
   assign mis_load  = misaligned_load_in;
   assign mis_store = misaligned_store_in;
`else
   logic unused_misaligned;
   assign unused_misaligned = &{misaligned_instr_in, misaligned_load_in, misaligned_store_in};
   assign mis_instr = 1'b0;
   assign mis_load  = 1'b0;
   assign mis_store = 1'b0;
`endif

   assign is_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000)
                   && (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
   assign is_ecall  = is_system && (rs2_addr_in == 5'b00000) && (funct7_in == 7'b0000000);
   assign is_ebreak = is_system && (rs2_addr_in == 5'b00001) && (funct7_in == 7'b0000000);
   assign is_mret   = is_system && (rs2_addr_in == 5'b00010) && (funct7_in == 7'b0011000);

   // Exception priority chain, highest first.
   always_comb begin
      exc       = 1'b1;
      exc_mis   = 1'b0;
      exc_cause = 4'd0;
      if (illegal_instr_in) begin
         exc_cause = 4'd2;
      end else if (mis_instr) begin
         exc_cause = 4'd0;
         exc_mis   = 1'b1;
      end else if (is_ecall) begin
         exc_cause = 4'd11;
      end else if (is_ebreak) begin
         exc_cause = 4'd3;
      end else if (mis_load) begin
         exc_cause = 4'd4;
         exc_mis   = 1'b1;
      end else if (mis_store) begin
         exc_cause = 4'd6;
         exc_mis   = 1'b1;
      end else begin
         exc = 1'b0;
      end
   end

   // Interrupt priority MEI > MSI > MTI, gated by the global enable.
   always_comb begin
      irq       = 1'b0;
      irq_cause = 4'd0;
      if (mie_in) begin
         if (meie_in && meip_in) begin
            irq       = 1'b1;
            irq_cause = 4'd11;
         end else if (msie_in && msip_in) begin
            irq       = 1'b1;
            irq_cause = 4'd3;
         end else if (mtie_in && mtip_in) begin
            irq       = 1'b1;
            irq_cause = 4'd7;
         end
      end
   end

   assign trap = exc | irq;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= RESET;
      end else begin
         state <= next_state;
      end
   end

   // Trap descriptor is latched on the detection edge and held until the next trap.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cause_out                <= 4'd0;
         i_or_e_out               <= 1'b0;
         misaligned_exception_out <= 1'b0;
      end else if (state == OPERATING && trap) begin
         cause_out                <= exc ? exc_cause : irq_cause;
         i_or_e_out               <= ~exc;
         misaligned_exception_out <= exc & exc_mis;
      end
   end

   always_comb begin
      next_state      = state;
      pc_src_out      = 2'b11;
      flush_out       = 1'b0;
      set_cause_out   = 1'b0;
      set_epc_out     = 1'b0;
      instret_inc_out = 1'b0;
      mie_clear_out   = 1'b0;
      mie_set_out     = 1'b0;
      case (state)
         RESET: begin
            next_state = OPERATING;
            pc_src_out = 2'b00;
            flush_out  = 1'b1;
         end
         OPERATING: begin
            // An interrupt alongside MRET takes the trap; MRET is not executed.
            if (trap) begin
               next_state = TRAP_TAKEN;
               flush_out  = 1'b1;
            end else if (is_mret) begin
               next_state = TRAP_RETURN;
               flush_out  = 1'b1;
            end else begin
               instret_inc_out = 1'b1;
            end
         end
         TRAP_TAKEN: begin
            next_state    = OPERATING;
            set_cause_out = 1'b1;
            set_epc_out   = 1'b1;
            mie_clear_out = 1'b1;
            pc_src_out    = 2'b10;
            flush_out     = 1'b1;
         end
         TRAP_RETURN: begin
            next_state  = OPERATING;
            mie_set_out = 1'b1;
            pc_src_out  = 2'b01;
            flush_out   = 1'b1;
         end
         default: begin
            next_state = RESET;
         end
      endcase
   end

endmodule

// File: doc/msrv32_trap_ctrl.md
# msrv32_trap_ctrl

Machine-mode trap and interrupt controller for the msrv32 core. It sits on the initiator side of the CSR file's trap interface and drives that interface. It detects synchronous exceptions, enabled pending interrupts and MRET, and sequences trap entry and return through a 4-state FSM. It also drives the PC-source select, pipeline flush and instret increment.

## Interface
Parameters: none.

Ports:
- clk_in  input  1  core clock
- rst_in  input  1  reset; asynchronous, active-high
- opcode_6_to_2_in  input  5  instruction opcode bits [6:2]
- funct3_in  input  3  instruction funct3
- funct7_in  input  7  instruction funct7
- rs1_addr_in, rs2_addr_in, rd_addr_in  input  5 each  instruction register fields
- illegal_instr_in  input  1  decoder flags illegal instruction
- misaligned_instr_in, misaligned_load_in, misaligned_store_in  input  1 each  address-misaligned flags
- mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in  input  1 each  enable/pending bits from the CSR file
- i_or_e_out  output  1  1 = interrupt trap, 0 = exception trap
- set_cause_out  output  1  write cause_out into mcause
- cause_out  output  4  trap cause code
- set_epc_out  output  1  capture PC into mepc
- instret_inc_out  output  1  retire current instruction
- mie_clear_out, mie_set_out  output  1 each  clear/set mstatus.MIE
- misaligned_exception_out  output  1  trap is a misaligned exception
- pc_src_out  output  2  00 boot, 01 mepc, 10 trap vector, 11 next PC
- flush_out  output  1  kill the instruction in the pipeline

## Operation
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
- Instruction decode: SYSTEM = opcode 11100, funct3 000, rs1 = rd = 0.
  - ECALL: SYSTEM with rs2 00000, funct7 0.
  - EBREAK: SYSTEM with rs2 00001, funct7 0.
  - MRET: SYSTEM with rs2 00010, funct7 0011000.
- Exception priority, highest first, with cause:
  - illegal: 2
  - instr misaligned: 0
  - ECALL: 11
  - EBREAK: 3
  - load misaligned: 4
  - store misaligned: 6
- Interrupt, evaluated only if no exception and mie_in = 1, priority MEI (11) > MSI (3) > MTI (7). Each requires its enable and pending bits both set.
- Exceptions take precedence over interrupts in the same cycle.
- Transitions:
  - RESET → OPERATING: unconditional.
  - OPERATING → TRAP_TAKEN: on exception or interrupt.
  - OPERATING → TRAP_RETURN: on MRET with no exception or interrupt.
  - OPERATING → OPERATING: otherwise.
  - TRAP_TAKEN → OPERATING.
  - TRAP_RETURN → OPERATING.
- Outputs per state:
  - RESET: pc_src 00, flush 1, all strobes 0.
  - OPERATING, no event: pc_src 11, instret_inc 1, flush 0.
  - OPERATING, event detected: instret_inc 0, flush 1, pc_src 11.
  - TRAP_TAKEN: set_cause 1, set_epc 1, mie_clear 1, pc_src 10, flush 1. i_or_e and misaligned_exception reflect the registered trap.
  - TRAP_RETURN: mie_set 1, pc_src 01, flush 1.
- cause_out, i_or_e_out and misaligned_exception_out are registered on the detection edge and hold until the next trap.

## Timing
- Reset values:
  - state RESET, cause_out 0, i_or_e_out 0, misaligned_exception_out 0.
  - Combinational outputs in RESET: pc_src_out 00, flush_out 1, all other strobes 0.
- Trap latency: condition seen in cycle N (OPERATING). TRAP_TAKEN strobes are high for exactly cycle N+1. Back in OPERATING at N+2.
- MRET: mie_set_out and pc_src 01 for exactly cycle N+1.
- Conditions arriving while in TRAP_TAKEN or TRAP_RETURN are ignored. They are re-evaluated in OPERATING; level-held pending interrupts therefore re-trigger.
- An interrupt arriving in the same cycle as MRET takes the trap; MRET is not executed.
- rst_in asserted mid-trap forces RESET immediately. No strobe may remain high after the asynchronous assertion.

## Configuration
- MSRV32_MISALIGNED_TRAP_EN defined: misaligned_instr/load/store inputs raise exceptions with causes 0/4/6, and misaligned_exception_out = 1 for those traps.
- Macro undefined:
  - The three misaligned inputs are ignored.
  - Causes 0, 4 and 6 are never produced.
  - misaligned_exception_out is constant 0.

## Test plan
- Release reset → 1 cycle RESET (pc_src 00, flush 1), then OPERATING with pc_src 11 and instret_inc 1.
- ECALL encoding in OPERATING → next cycle set_cause = set_epc = mie_clear = 1, cause_out 11, i_or_e 0, pc_src 10; then OPERATING.
- mie/meie/meip/msie/msip all 1 → cause 11, i_or_e 1; with only mtie and mtip set → cause 7.
- Illegal instruction plus meip/meie/mie set → exception wins, cause 2, i_or_e 0.
- MRET → one cycle of mie_set 1, pc_src 01; MRET with an enabled timer interrupt pending → trap, cause 7, mie_set stays 0.
- misaligned_load_in = 1:
  - With MSRV32_MISALIGNED_TRAP_EN → cause 4, misaligned_exception_out 1.
  - Without → no trap, instret_inc 1.
- rst_in asserted in TRAP_TAKEN → all strobes 0 immediately, state RESET.
